pipelined_inst_decoder: RTL and testbench



---
 rtl/pipelined_inst_decoder.sv | 192 +++++++++++++++++++
 tb/tb_pipelined_inst_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_inst_decoder.sv
// KGP-RISC decode stage: splits an instruction into fields and control flags behind a
// one-entry valid/ready output register, with a load-use bubble inserter and branch flush.
module pipelined_inst_decoder #(
  parameter int REG_W        = 5,
  parameter int FUNC_W       = 4,   // bits [3:1] are interpreted, so at least 4
  parameter int IMM_W        = 16,
  parameter int DATA_W       = 32,
  parameter int STALL_CYCLES = 1,
  localparam int INST_W      = 2 + 2*REG_W + FUNC_W + IMM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        opcode,
  output logic [REG_W-1:0]  rs,
  output logic [REG_W-1:0]  rt,
  output logic [REG_W-1:0]  shamt,
  output logic [FUNC_W-1:0] func,
  output logic [DATA_W-1:0] offset,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              is_branch
);

  localparam int FUNC_LSB = IMM_W;
  localparam int RT_LSB   = FUNC_LSB + FUNC_W;
  localparam int RS_LSB   = RT_LSB + REG_W;
  localparam int OP_LSB   = RS_LSB + REG_W;

  localparam int CNT_W = (STALL_CYCLES < 1) ? 1 : $clog2(STALL_CYCLES + 1);

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BRANCH= 2'b11;

  typedef struct packed {
    logic [1:0]        opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  shamt;
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] offset;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              is_branch;
  } bundle_t;

  // Raw instruction fields
  logic [1:0]        f_op;
  logic [REG_W-1:0]  f_rs;
  logic [REG_W-1:0]  f_rt;
  logic [FUNC_W-1:0] f_func;
  logic [IMM_W-1:0]  f_off;
  logic [DATA_W-1:0] f_sext;

  assign f_op   = inst[OP_LSB +: 2];
  assign f_rs   = inst[RS_LSB +: REG_W];
  assign f_rt   = inst[RT_LSB +: REG_W];
  assign f_func = inst[FUNC_LSB +: FUNC_W];
  assign f_off  = inst[0 +: IMM_W];
  assign f_sext = DATA_W'($signed(f_off));

  bundle_t dec;
  logic    uses_rs;
  logic    uses_rt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one
    // unassigned and infer a latch.
    dec        = '0;
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    dec.opcode = f_op;
    unique case (f_op)
      OP_ALU: begin
        dec.rs        = f_rs;
        dec.func      = f_func;
        dec.reg_write = 1'b1;
        uses_rs       = 1'b1;
        if (f_func[3]) begin
          dec.shamt = f_rt;
        end else begin
          dec.rt  = f_rt;
          uses_rt = 1'b1;
        end
        if (f_func[2:1] == 2'b10) dec.offset = f_sext;
      end
      OP_LOAD: begin
        dec.rs        = f_rs;
        dec.rt        = f_rt;
        dec.func      = f_func;
        dec.offset    = f_sext;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        uses_rs       = 1'b1;
      end
      OP_STORE: begin
        dec.rs        = f_rs;
        dec.rt        = f_rt;
        dec.func      = f_func;
        dec.offset    = f_sext;
        dec.mem_write = (f_func == FUNC_W'(1));
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BRANCH: begin
        dec.is_branch = 1'b1;
        if (f_func[3]) begin
          dec.rs     = f_rs;
          dec.rt     = f_rt;
          dec.offset = f_sext;
          uses_rs    = 1'b1;
          uses_rt    = 1'b1;
        end else if (f_func[3:1] == 3'b000) begin
          dec.offset = f_sext;
        end else if (f_func[3:1] == 3'b001) begin
          // return: no operands
        end else begin
          dec.rs     = f_rs;
          dec.offset = f_sext;
          uses_rs    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Load-use hazard state
  logic [CNT_W-1:0] cnt;
  logic [REG_W-1:0] ld_dst;
  logic             hazard;
  logic             accept;
  logic             load_sets_dst;

  // A zero destination can never match because ld_dst is only written with nonzero values.
  assign hazard = (cnt != '0) && in_valid && (ld_dst != '0) &&
                  ((uses_rs && (dec.rs == ld_dst)) || (uses_rt && (dec.rt == ld_dst)));

  assign in_ready      = !rst && !flush && !hazard && (!out_valid || out_ready);
  assign accept        = in_valid && in_ready;
  assign load_sets_dst = (f_op == OP_LOAD) && (f_rt != '0);

  bundle_t out_q;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      ld_dst    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && load_sets_dst) begin
        cnt    <= CNT_W'(STALL_CYCLES);
        ld_dst <= f_rt;
      end else if (out_ready && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign opcode    = out_q.opcode;
  assign rs        = out_q.rs;
  assign rt        = out_q.rt;
  assign shamt     = out_q.shamt;
  assign func      = out_q.func;
  assign offset    = out_q.offset;
  assign mem_read  = out_q.mem_read;
  assign mem_write = out_q.mem_write;
  assign reg_write = out_q.reg_write;
  assign is_branch = out_q.is_branch;

endmodule

// File: tb/tb_pipelined_inst_decoder.sv
// Scoreboard bench for pipelined_inst_decoder: a driver pushes reference-model bundles on
// accept and a negedge monitor compares whatever the decoder presents.
module tb_pipelined_inst_decoder;

  localparam int STALL = 1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] inst;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [1:0]  opcode;
  logic [4:0]  rs, rt, shamt;
  logic [3:0]  func;
  logic [31:0] offset;
  logic        mem_read, mem_write, reg_write, is_branch;

  logic        d0_in_ready, d0_out_valid;
  logic [1:0]  d0_opcode;
  logic [4:0]  d0_rs, d0_rt, d0_shamt;
  logic [3:0]  d0_func;
  logic [31:0] d0_offset;
  logic        d0_mem_read, d0_mem_write, d0_reg_write, d0_is_branch;

  pipelined_inst_decoder #(.STALL_CYCLES(STALL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .rs(rs), .rt(rt), .shamt(shamt), .func(func), .offset(offset),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .is_branch(is_branch)
  );

  // Second copy with the hazard unit disabled, used only in the load-use comparison.
  pipelined_inst_decoder #(.STALL_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready), .inst(inst),
    .flush(flush), .out_valid(d0_out_valid), .out_ready(out_ready), .opcode(d0_opcode),
    .rs(d0_rs), .rt(d0_rt), .shamt(d0_shamt), .func(d0_func), .offset(d0_offset),
    .mem_read(d0_mem_read), .mem_write(d0_mem_write), .reg_write(d0_reg_write),
    .is_branch(d0_is_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  opcode;
    logic [4:0]  rs, rt, shamt;
    logic [3:0]  func;
    logic [31:0] offset;
    logic        mem_read, mem_write, reg_write, is_branch;
  } bundle_t;

  int      n_checks = 0;
  int      n_errors = 0;
  bundle_t sb[$];
  int      stall_left = 0;
  int      load_dst   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t dut_bundle();
    return {opcode, rs, rt, shamt, func, offset, mem_read, mem_write, reg_write, is_branch};
  endfunction

  // Reference decode: decide which fields each instruction class exposes, then copy them.
  function automatic bundle_t ref_decode(input logic [31:0] i, output bit urs, output bit urt);
    bundle_t b;
    int op, f;
    bit d_rs, d_rt, d_sh, d_func, d_off;
    op = int'(i[31:30]);
    f  = int'(i[19:16]);
    b  = '0;
    {d_rs, d_rt, d_sh, d_func, d_off} = '0;
    b.opcode = i[31:30];
    case (op)
      0: begin
        d_rs = 1; d_func = 1; b.reg_write = 1;
        if (f >= 8) d_sh = 1; else d_rt = 1;
        d_off = (((f >> 1) & 3) == 2);
      end
      1: begin
        d_rs = 1; d_rt = 1; d_func = 1; d_off = 1;
        b.mem_read = 1; b.reg_write = 1;
      end
      2: begin
        d_rs = 1; d_rt = 1; d_func = 1; d_off = 1;
        b.mem_write = (f == 1);
      end
      default: begin
        b.is_branch = 1;
        if (f >= 8)     begin d_rs = 1; d_rt = 1; d_off = 1; end
        else if (f < 2) d_off = 1;
        else if (f < 4) ;
        else            begin d_rs = 1; d_off = 1; end
      end
    endcase
    if (d_rs)   b.rs     = i[29:25];
    if (d_rt)   b.rt     = i[24:20];
    if (d_sh)   b.shamt  = i[24:20];
    if (d_func) b.func   = i[19:16];
    if (d_off)  b.offset = 32'($signed(i[15:0]));
    urs = d_rs;
    urt = d_rt && (op != 1);
    return b;
  endfunction

  // One clock of stimulus; the model decides acceptance and records what must come out.
  task automatic cycle(input logic v, input logic [31:0] i, input logic ordy, input logic fl,
                       output logic acc);
    bit      urs, urt;
    bundle_t e;
    logic    hz, exp_rdy;
    @(posedge clk); #1;
    in_valid = v; inst = i; out_ready = ordy; flush = fl;
    e  = ref_decode(i, urs, urt);
    hz = (stall_left > 0) && v && (load_dst != 0) &&
         ((urs && int'(e.rs) == load_dst) || (urt && int'(e.rt) == load_dst));
    exp_rdy = !fl && !hz && (sb.size() == 0 || ordy);
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    #1;
    if (fl) begin
      sb.delete();
      stall_left = 0;
    end else begin
      if (acc) sb.push_back(e);
      if (acc && e.opcode == 2'b01 && e.rt != 0) begin
        stall_left = STALL;
        load_dst   = int'(e.rt);
      end else if (ordy && stall_left > 0) begin
        stall_left--;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; in_valid = 0; inst = '0; out_ready = 0; flush = 0;
    @(posedge clk); #1;
    rst = 0;
    sb.delete();
    stall_left = 0;
    load_dst   = 0;
  endtask

  // Monitor: whatever is held must match the oldest outstanding bundle; out_ready pops it.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("bundle", 64'(dut_bundle()), 64'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic acc;
    rst = 1; in_valid = 1; inst = 32'h4850FFFC; out_ready = 1; flush = 0;

    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_outputs", 64'(dut_bundle()), 64'(0));
    end
    @(posedge clk); #1;
    rst = 0; in_valid = 0; inst = '0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'(1));

    // Back-to-back ALU at full throughput
    cycle(1, 32'h02200000, 1, 0, acc);
    check("alu0_acc", 64'(acc), 64'(1));
    cycle(1, 32'h06308000, 1, 0, acc);
    check("alu1_acc", 64'(acc), 64'(1));
    check("alu0_fields", {out_valid, opcode, rs, rt, reg_write},
          {1'b1, 2'b00, 5'd1, 5'd2, 1'b1});
    cycle(0, 32'h0, 1, 0, acc);

    // Load then dependent ALU: one stall cycle, one bubble; no stall without the hazard unit
    do_reset();
    cycle(1, 32'h4850FFFC, 1, 0, acc);
    cycle(1, 32'h0A100000, 1, 0, acc);
    check("load_fields", {rs, rt, offset, mem_read, reg_write, mem_write},
          {5'd4, 5'd5, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0});
    check("lu_stall", 64'(in_ready), 64'(0));
    check("lu_nostall_d0", 64'(d0_in_ready), 64'(1));
    cycle(1, 32'h0A100000, 1, 0, acc);
    check("lu_accept_after_stall", 64'(acc), 64'(1));
    check("lu_bubble", 64'(out_valid), 64'(0));
    check("lu_d0_no_bubble", {d0_out_valid, d0_rs}, {1'b1, 5'd5});
    cycle(0, 32'h0, 1, 0, acc);
    check("lu_alu_out", {out_valid, rs, rt}, {1'b1, 5'd5, 5'd1});

    // Backpressure on a held store
    do_reset();
    cycle(1, 32'h84710008, 1, 0, acc);
    repeat (3) begin
      cycle(1, 32'h02200000, 0, 0, acc);
      check("bp_hold", {out_valid, rs, rt, func, offset, mem_write, in_ready},
            {1'b1, 5'd2, 5'd7, 4'd1, 32'd8, 1'b1, 1'b0});
    end
    cycle(0, 32'h0, 1, 0, acc);
    cycle(0, 32'h0, 1, 0, acc);
    check("bp_single_transfer", 64'(out_valid), 64'(0));

    // Flush with a held load and a live stall count
    cycle(1, 32'h4850FFFC, 1, 0, acc);
    cycle(0, 32'h0, 0, 1, acc);
    cycle(1, 32'h0A100000, 1, 0, acc);
    check("flush_cleared_valid", 64'(out_valid), 64'(0));
    check("flush_cleared_hazard", 64'(acc), 64'(1));
    cycle(0, 32'h0, 1, 0, acc);

    // Randomised traffic with a small register range to provoke hazards
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r;
      r = {2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 16'($urandom)};
      cycle(logic'($urandom_range(0, 3) != 0), r, logic'($urandom_range(0, 9) < 7),
            logic'($urandom_range(0, 19) == 0), acc);
    end
    repeat (3) cycle(0, 32'h0, 1, 0, acc);
    check("drained", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
